// File: rtl/seg7_word_decoder.sv
// seg7_word_decoder
//   Decodes a stream of active-low 7-segment patterns (bit0=a .. bit6=g) back
//   into hex digits and packs DIGITS of them into one word. The first digit
//   received ends up in the most significant nibble.
//
// Ports
//   Clock, Resetn        rising-edge clock, asynchronous active-low reset
//   SegIn/SegValid/SegReady    pattern input handshake
//   Clear                synchronous flush of word, errors and state
//   WordOut/WordValid/WordReady  assembled word output handshake
//   DigitCount           digits collected in the current word
//   BadCode              sticky flag: an undecodable pattern was received
//   ErrCount             count of undecodable patterns, saturating at 8'hFF
//   dbg_state            current FSM state (0 = COLLECT, 1 = HOLD)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid, once raised, is held with stable data until that edge;
// ready may change freely and never depends on valid.

module seg7_word_decoder #(
  parameter int DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [6:0]            SegIn,
  input  logic                  SegValid,
  output logic                  SegReady,
  input  logic                  Clear,
  output logic [4*DIGITS-1:0]   WordOut,
  output logic                  WordValid,
  input  logic                  WordReady,
  output logic [3:0]            DigitCount,
  output logic                  BadCode,
  output logic [7:0]            ErrCount,
  output logic                  dbg_state
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [3:0] DIGITS_C = 4'(DIGITS);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   word_q, word_d;
  logic [3:0]     count_q, count_d;
  logic           bad_q, bad_d;
  logic [7:0]     err_q, err_d;

  logic [3:0]     digit;
  logic           digit_ok;
  logic [W-1:0]   word_shift;
  logic           seg_accept;

  // Inverse of the team nibble-to-segment encoder; anything else is invalid.
  always_comb begin
    digit    = 4'h0;
    digit_ok = 1'b1;
    case (SegIn)
      7'h40:   digit = 4'h0;
      7'h79:   digit = 4'h1;
      7'h24:   digit = 4'h2;
      7'h30:   digit = 4'h3;
      7'h19:   digit = 4'h4;
      7'h12:   digit = 4'h5;
      7'h02:   digit = 4'h6;
      7'h78:   digit = 4'h7;
      7'h00:   digit = 4'h8;
      7'h18:   digit = 4'h9;
      7'h08:   digit = 4'hA;
      7'h03:   digit = 4'hB;
      7'h27:   digit = 4'hC;
      7'h21:   digit = 4'hD;
      7'h04:   digit = 4'hE;
      7'h0E:   digit = 4'hF;
      default: digit_ok = 1'b0;
    endcase
  end

  // A one-digit word has nothing to shift; the new digit is the whole word.
  if (DIGITS == 1) begin : g_one
    assign word_shift = digit;
  end else begin : g_multi
    assign word_shift = {word_q[W-5:0], digit};
  end

  // Ready is held low during reset and Clear so a pending pattern is kept.
  assign SegReady   = (state_q == COLLECT) & ~Clear & Resetn;
  assign seg_accept = SegValid & SegReady;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    bad_d   = bad_q;
    err_d   = err_q;
    if (Clear) begin
      state_d = COLLECT;
      word_d  = '0;
      count_d = 4'd0;
      bad_d   = 1'b0;
      err_d   = 8'd0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (seg_accept) begin
            if (digit_ok) begin
              word_d  = word_shift;
              count_d = count_q + 4'd1;
              if (count_q + 4'd1 == DIGITS_C) begin
                state_d = HOLD;
              end
            end else begin
              // Undecodable pattern: drop the partial word entirely.
              word_d  = '0;
              count_d = 4'd0;
              bad_d   = 1'b1;
              if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
              end
            end
          end
        end
        HOLD: begin
          // WordOut keeps its value after the handshake until the next shift.
          if (WordReady) begin
            state_d = COLLECT;
            count_d = 4'd0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= COLLECT;
      word_q  <= '0;
      count_q <= 4'd0;
      bad_q   <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  assign WordOut    = word_q;
  assign WordValid  = (state_q == HOLD);
  assign DigitCount = count_q;
  assign BadCode    = bad_q;
  assign ErrCount   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_word_decoder.sv
module tb_seg7_word_decoder;

  localparam int D = 2;
  localparam int W = 4 * D;

  // ---------------- clock / reset / DUT ----------------
  logic           Clock = 1'b0;
  logic           Resetn;
  logic [6:0]     SegIn;
  logic           SegValid;
  logic           SegReady;
  logic           Clear;
  logic [W-1:0]   WordOut;
  logic           WordValid;
  logic           WordReady;
  logic [3:0]     DigitCount;
  logic           BadCode;
  logic [7:0]     ErrCount;
  logic           dbg_state;

  always #5 Clock = ~Clock;

  seg7_word_decoder #(.DIGITS(D)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .SegIn      (SegIn),
    .SegValid   (SegValid),
    .SegReady   (SegReady),
    .Clear      (Clear),
    .WordOut    (WordOut),
    .WordValid  (WordValid),
    .WordReady  (WordReady),
    .DigitCount (DigitCount),
    .BadCode    (BadCode),
    .ErrCount   (ErrCount),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Encoder table: digit -> active-low segment pattern.
  function automatic logic [6:0] code_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h18;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h27; 13: return 7'h21; 14: return 7'h04; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Decode by searching the encoder table; -1 means not an encoder output.
  function automatic int decode_ref(input logic [6:0] c);
    for (int i = 0; i < 16; i++) begin
      if (code_of(i) == c) return i;
    end
    return -1;
  endfunction

  logic [W-1:0] m_word;
  int           m_count;
  bit           m_hold;
  bit           m_bad;
  int           m_err;
  logic [W-1:0] exp_q[$];
  int           hs_count = 0;

  task automatic model_reset();
    m_word  = '0;
    m_count = 0;
    m_hold  = 1'b0;
    m_bad   = 1'b0;
    m_err   = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [6:0] c);
    int d;
    d = decode_ref(c);
    if (d < 0) begin
      m_word  = '0;
      m_count = 0;
      m_bad   = 1'b1;
      if (m_err < 255) m_err++;
    end else begin
      m_word = (m_word << 4) | W'(d);
      m_count++;
      if (m_count == D) begin
        m_hold = 1'b1;
        exp_q.push_back(m_word);
      end
    end
  endtask

  function automatic logic [6:0] rand_valid();
    return code_of(int'($urandom_range(0, 15)));
  endfunction

  function automatic logic [6:0] rand_invalid();
    logic [6:0] c;
    do begin
      c = 7'($urandom_range(0, 127));
    end while (decode_ref(c) >= 0);
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  // Inputs change just after rising edges, so at a falling edge everything
  // is stable: a handshake seen here completes on the next rising edge.
  always @(negedge Clock) begin
    if (Resetn && !Clear && WordValid && WordReady) begin
      logic [W-1:0] exp_w;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word_unexpected: got %h want none", WordOut);
      end else begin
        exp_w = exp_q.pop_front();
        if (WordOut !== exp_w) begin
          bad++;
          $display("FAIL word_out: got %h want %h", WordOut, exp_w);
        end
      end
      hs_count++;
      @(posedge Clock);
      m_hold  = 1'b0;
      m_count = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [6:0] c);
    bit done;
    bit exp_rdy;
    done     = 1'b0;
    SegIn    = c;
    SegValid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge Clock);
      exp_rdy = !m_hold && !Clear;
      total++;
      if (SegReady !== exp_rdy) begin
        bad++;
        $display("FAIL seg_ready: got %b want %b (code %h)", SegReady, exp_rdy, c);
      end
      if (exp_rdy) begin
        model_accept(c);
        done = 1'b1;
      end
      @(posedge Clock); #1;
    end
    SegValid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept want accept (code %h)", c);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 20 && m_hold; n++) begin
      @(posedge Clock); #1;
    end
    total++;
    if (m_hold || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    @(negedge Clock);
    total++;
    if (SegReady !== 1'b0) begin
      bad++;
      $display("FAIL clear_ready: got %b want 0", SegReady);
    end
    @(posedge Clock); #1;
    Clear = 1'b0;
    model_reset();
    @(negedge Clock);
    total++;
    if (BadCode !== 1'b0 || ErrCount !== 8'h00 || DigitCount !== 4'd0 ||
        WordValid !== 1'b0 || WordOut !== '0) begin
      bad++;
      $display("FAIL clear_state: got bad=%b err=%h cnt=%0d v=%b w=%h want all 0",
               BadCode, ErrCount, DigitCount, WordValid, WordOut);
    end
    @(posedge Clock); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Resetn = 1'b0; SegIn = 7'h00; SegValid = 1'b0; Clear = 1'b0; WordReady = 1'b0;
    model_reset();
    @(negedge Clock);
    total++;
    if (WordOut !== '0 || WordValid !== 1'b0 || DigitCount !== 4'd0 ||
        BadCode !== 1'b0 || ErrCount !== 8'h00 || SegReady !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got w=%h v=%b cnt=%0d bad=%b err=%h rdy=%b want all 0",
               WordOut, WordValid, DigitCount, BadCode, ErrCount, SegReady);
    end
    @(posedge Clock); #1;
    Resetn = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_basic_word();
    WordReady = 1'b0;
    send(7'h30);
    send(7'h12);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      total++;
      if (WordValid !== 1'b1 || WordOut !== 8'h35 || DigitCount !== 4'd2 ||
          SegReady !== 1'b0) begin
        bad++;
        $display("FAIL basic_hold: got v=%b w=%h cnt=%0d rdy=%b want 1 35 2 0",
                 WordValid, WordOut, DigitCount, SegReady);
      end
      @(posedge Clock); #1;
    end
    WordReady = 1'b1;
    wait_drain();
    WordReady = 1'b0;
    @(negedge Clock);
    total++;
    if (WordValid !== 1'b0 || DigitCount !== 4'd0 || WordOut !== 8'h35) begin
      bad++;
      $display("FAIL basic_after: got v=%b cnt=%0d w=%h want 0 0 35",
               WordValid, DigitCount, WordOut);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_sweep();
    int hs0;
    hs0 = hs_count;
    WordReady = 1'b1;
    for (int i = 0; i < 16; i++) send(code_of(i));
    wait_drain();
    total++;
    if (hs_count - hs0 != 8 || BadCode !== 1'b0) begin
      bad++;
      $display("FAIL sweep: got words=%0d bad=%b want 8 0", hs_count - hs0, BadCode);
    end
  endtask

  task automatic test_invalid_abort();
    do_clear();
    WordReady = 1'b1;
    send(7'h79);
    send(7'h7F);
    @(negedge Clock);
    total++;
    if (DigitCount !== 4'd0 || WordOut !== 8'h00 || BadCode !== 1'b1 ||
        ErrCount !== 8'd1) begin
      bad++;
      $display("FAIL invalid_abort: got cnt=%0d w=%h bad=%b err=%h want 0 00 1 01",
               DigitCount, WordOut, BadCode, ErrCount);
    end
    @(posedge Clock); #1;
    send(7'h24);
    send(7'h40);
    wait_drain();
    @(negedge Clock);
    total++;
    if (WordOut !== 8'h20) begin
      bad++;
      $display("FAIL invalid_next_word: got %h want 20", WordOut);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_saturate();
    do_clear();
    for (int i = 0; i < 300; i++) send(rand_invalid());
    @(negedge Clock);
    total++;
    if (ErrCount !== 8'hFF || BadCode !== 1'b1 || m_err != 255) begin
      bad++;
      $display("FAIL saturate: got err=%h bad=%b want ff 1", ErrCount, BadCode);
    end
    @(posedge Clock); #1;
    do_clear();
  endtask

  task automatic test_hold_handshake();
    WordReady = 1'b0;
    send(rand_valid());
    send(rand_valid());
    // Handshake and a waiting digit in the same cycle: digit must wait one.
    WordReady = 1'b1;
    send(rand_valid());
    WordReady = 1'b0;
    @(negedge Clock);
    total++;
    if (DigitCount !== 4'd1 || m_count != 1) begin
      bad++;
      $display("FAIL hold_next_digit: got cnt=%0d want 1", DigitCount);
    end
    @(posedge Clock); #1;
    SegIn = rand_valid(); SegValid = 1'b1; Clear = 1'b1;
    @(negedge Clock);
    total++;
    if (SegReady !== 1'b0) begin
      bad++;
      $display("FAIL clear_blocks_ready: got %b want 0", SegReady);
    end
    @(posedge Clock); #1;
    Clear = 1'b0; SegValid = 1'b0;
    model_reset();
    @(negedge Clock);
    total++;
    if (DigitCount !== 4'd0 || WordOut !== '0) begin
      bad++;
      $display("FAIL clear_no_accept: got cnt=%0d w=%h want 0 00", DigitCount, WordOut);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_async_reset();
    WordReady = 1'b0;
    send(rand_valid());
    Resetn = 1'b0;
    #2;
    total++;
    if (WordOut !== '0 || WordValid !== 1'b0 || DigitCount !== 4'd0 ||
        SegReady !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_mid: got w=%h v=%b cnt=%0d rdy=%b want 0",
               WordOut, WordValid, DigitCount, SegReady);
    end
    @(posedge Clock); #1;
    Resetn = 1'b1;
    model_reset();
    send(rand_valid());
    send(rand_valid());
    Resetn = 1'b0;
    #2;
    total++;
    if (WordOut !== '0 || WordValid !== 1'b0 || DigitCount !== 4'd0 ||
        BadCode !== 1'b0 || ErrCount !== 8'h00) begin
      bad++;
      $display("FAIL async_reset_hold: got w=%h v=%b cnt=%0d bad=%b err=%h want 0",
               WordOut, WordValid, DigitCount, BadCode, ErrCount);
    end
    @(posedge Clock); #1;
    Resetn = 1'b1;
    model_reset();
    WordReady = 1'b1;
    send(rand_valid());
    send(rand_valid());
    wait_drain();
  endtask

  task automatic test_back_to_back();
    do_clear();
    WordReady = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) send(rand_invalid());
      else                          send(rand_valid());
    end
    wait_drain();
    @(negedge Clock);
    total++;
    if (BadCode !== m_bad || ErrCount !== 8'(m_err) || DigitCount !== 4'(m_count)) begin
      bad++;
      $display("FAIL back_to_back: got bad=%b err=%h cnt=%0d want %b %h %0d",
               BadCode, ErrCount, DigitCount, m_bad, 8'(m_err), m_count);
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    @(posedge Clock); #1;
    test_reset();
    test_basic_word();
    test_sweep();
    test_invalid_abort();
    test_saturate();
    test_hold_handshake();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
